// File: rtl/ibus_fetch_unit_pkg.sv
// Shared instruction-bus package: transfer encodings, fetch FSM states and
// the fetch buffer entry layout used by ibus_fetch_unit and its bus interface.
package ibus_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } tsize_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

  // One buffered fetch result; a fault entry carries data = 0.
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  function automatic logic is_misaligned(input logic [XLEN-1:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ibus_fetch_unit_if.sv
// Instruction bus: request/grant arbitration, one-cycle start strobe, and a
// completion (bdone) with optional error (berror).
//   master: breq, bstart, addr, tsize, ttype, wdata out; bgnt, rdata, bdone, berror in
//   slave : mirror image of master
interface master_bus_if;
  import ibus_fetch_unit_pkg::*;

  logic            breq;
  logic            bgnt;
  logic            bstart;
  logic [XLEN-1:0] addr;
  tsize_t          tsize;
  ttype_t          ttype;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            bdone;
  logic            berror;

  modport master (
    output breq, bstart, addr, tsize, ttype, wdata,
    input  bgnt, rdata, bdone, berror
  );

  modport slave (
    input  breq, bstart, addr, tsize, ttype, wdata,
    output bgnt, rdata, bdone, berror
  );

endinterface

// File: rtl/ibus_fetch_unit_fifo.sv
// Small synchronous FIFO holding fetch results between the bus and decode.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
//   clk, rst_n        : clock, synchronous active-low reset
//   flush             : drop all entries (wins over push/pop)
//   push, push_data   : write side
//   pop, pop_data     : read side; pop_data shows the head entry
//   full, empty, count: occupancy
module fetch_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ibus_fetch_unit.sv
// Instruction fetch unit: issues one read at a time on the instruction bus,
// buffers results in a 2-entry FIFO and presents them to decode. Bus errors,
// completion timeouts and misaligned PCs produce a fault entry and halt
// fetching until a redirect.
//   clk, rst_n                 : clock, synchronous active-low reset
//   ibus_if (master)           : instruction bus
//   redirect_valid/redirect_pc : flush and restart fetch at a new PC
//   inst_valid/inst_ready      : decode handshake
//   inst_data/inst_pc/inst_fault: FIFO head (zero when empty)
module ibus_fetch_unit
  import ibus_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h2000_0000,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  master_bus_if.master        ibus_if,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [31:0]         inst_data,
  output logic [31:0]         inst_pc,
  output logic                inst_fault
);

  localparam int unsigned CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FCNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W      = FCNT_W + 1;

  fetch_state_t      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       addr_q;
  logic              killed_q, killed_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              breq_q, bstart_q;
  logic              timeout;
  logic              wait_done;
  logic              in_flight;
  logic              slot_free;

  logic              push, pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [FCNT_W-1:0] fifo_count;

  assign timeout   = (cnt_q == CNT_W'(TIMEOUT));
  assign in_flight = state_q inside {REQ, START, WAIT};
  assign slot_free = !fifo_full &&
                     ((OCC_W'(fifo_count) + OCC_W'(in_flight)) < OCC_W'(FIFO_DEPTH));

  // Next-state, PC and buffer push decisions; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    killed_d   = killed_q;
    push       = 1'b0;
    push_entry = '0;
    wait_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (slot_free) begin
          if (is_misaligned(pc_q)) begin
            push             = 1'b1;
            push_entry.pc    = pc_q;
            push_entry.fault = 1'b1;
            state_d          = HALT;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ:   if (ibus_if.bgnt) state_d = START;
      START: state_d = WAIT;
      WAIT: begin
        if (ibus_if.bdone || timeout) begin
          wait_done = 1'b1;
          state_d   = IDLE;
          killed_d  = 1'b0;
          // A killed response is consumed here and its data discarded.
          if (!killed_q) begin
            push          = 1'b1;
            push_entry.pc = addr_q;
            if (ibus_if.bdone && !ibus_if.berror) begin
              push_entry.data = ibus_if.rdata;
              pc_d            = addr_q + 32'd4;
            end else begin
              push_entry.fault = 1'b1;
              state_d          = HALT;
            end
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      push = 1'b0;
      pc_d = redirect_pc;
      if (state_q == START || (state_q == WAIT && !wait_done)) begin
        // Transaction must still complete on the bus; drop its result later.
        killed_d = 1'b1;
      end else begin
        killed_d = 1'b0;
        state_d  = is_misaligned(redirect_pc) ? IDLE : REQ;
      end
    end
  end

  // State, PC and registered bus outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      killed_q <= 1'b0;
      cnt_q    <= '0;
      breq_q   <= 1'b0;
      bstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      killed_q <= killed_d;
      // Address is frozen once the transaction has been granted.
      if (state_d != START && state_d != WAIT) addr_q <= pc_d;
      breq_q   <= state_d inside {REQ, START, WAIT};
      bstart_q <= (state_d == START);
      if (state_q != WAIT)  cnt_q <= '0;
      else if (!timeout)    cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ibus_if.breq   = breq_q;
  assign ibus_if.bstart = bstart_q;
  assign ibus_if.addr   = addr_q;
  assign ibus_if.tsize  = WORD;
  assign ibus_if.ttype  = READ;
  assign ibus_if.wdata  = '0;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head       = fetch_entry_t'(fifo_rdata);
  assign inst_valid = !fifo_empty;
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = fifo_empty ? '0 : head.data;
  assign inst_pc    = fifo_empty ? '0 : head.pc;
  assign inst_fault = fifo_empty ? 1'b0 : head.fault;

endmodule

// File: tb/tb_ibus_fetch_unit.sv
// Bench for ibus_fetch_unit: a simple bus slave (grant = request, completion
// the cycle after the start strobe, read data = address) plus a scoreboard
// queue consumed by a monitor on every accepted instruction.
module tb_ibus_fetch_unit;
  import ibus_fetch_unit_pkg::*;

  localparam logic [31:0] UNMAPPED = 32'h5000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;

  master_bus_if bus ();

  ibus_fetch_unit #(
    .RESET_PC (32'h2000_0000),
    .TIMEOUT  (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ibus_if        (bus.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  always #5 clk = ~clk;

  // Slave model; the unmapped address never completes.
  assign bus.bgnt = bus.breq;
  always @(posedge clk) begin
    bus.bdone  <= bus.bstart && (bus.addr != UNMAPPED);
    bus.berror <= bus.bstart && (bus.addr != UNMAPPED) && (bus.addr == err_addr);
    bus.rdata  <= bus.addr;
  end

  // Monitor: every accepted instruction is matched against the queue head.
  always @(negedge clk) begin
    if (inst_valid && inst_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_entry: got pc=%h data=%h fault=%0b, required no entry",
                 inst_pc, inst_data, inst_fault);
      end else begin
        mon_e = exp_q.pop_front();
        if (inst_pc === mon_e.pc && inst_data === mon_e.data && inst_fault === mon_e.fault)
          n_pass++;
        else
          $display("FAIL entry: got pc=%h data=%h fault=%0b, required pc=%h data=%h fault=%0b",
                   inst_pc, inst_data, inst_fault, mon_e.pc, mon_e.data, mon_e.fault);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] data, input logic fault);
    fetch_entry_t e;
    e.pc = pc;
    e.data = data;
    e.fault = fault;
    exp_q.push_back(e);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
  endtask

  // Returns at the negedge of the START cycle.
  task automatic wait_bstart(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.bstart) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s: got no bstart within 50 cycles, required a bstart pulse", name);
    end
  endtask

  // Wait until every expected entry is consumed, then stop accepting.
  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d entries pending, required 0", exp_q.size());
      exp_q.delete();
    end
    #1 inst_ready = 1'b0;
  endtask

  task automatic check_bus_idle(input string name, input int cycles);
    logic any_req = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      any_req = any_req | bus.breq | bus.bstart;
    end
    chk(name, 32'(any_req), 32'd0);
  endtask

  initial begin
    int lat;
    logic seen_bstart;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_breq",       32'(bus.breq),   32'd0);
    chk("rst_bstart",     32'(bus.bstart), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_fault", 32'(inst_fault), 32'd0);
    chk("rst_inst_data",  inst_data,       32'd0);
    chk("rst_inst_pc",    inst_pc,         32'd0);
    chk("rst_addr",       bus.addr,        32'h2000_0000);
    chk("tsize_word",     32'(bus.tsize),  32'd2);
    chk("ttype_read",     32'(bus.ttype),  32'd0);
    chk("wdata_zero",     bus.wdata,       32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-pressure: exactly two entries buffered, then the bus goes quiet.
    repeat (20) @(negedge clk);
    chk("bp_inst_valid", 32'(inst_valid), 32'd1);
    chk("bp_breq_quiet", 32'(bus.breq),   32'd0);
    chk("bp_head_pc",    inst_pc,         32'h2000_0000);
    chk("bp_head_data",  inst_data,       32'h2000_0000);
    for (int i = 0; i < 5; i++)
      expect_entry(32'h2000_0000 + 32'(4 * i), 32'h2000_0000 + 32'(4 * i), 1'b0);
    @(posedge clk);
    #1 inst_ready = 1'b1;
    drain(200);

    // Redirect during START: the in-flight response is killed.
    do_redirect(32'h3000_0000);
    wait_bstart("kill_start_bstart");
    chk("kill_start_addr", bus.addr, 32'h3000_0000);
    expect_entry(32'hF000_0200, 32'hF000_0200, 1'b0);
    expect_entry(32'hF000_0204, 32'hF000_0204, 1'b0);
    do_redirect(32'hF000_0200);
    inst_ready = 1'b1;
    drain(100);

    // Redirect in WAIT together with bdone: stale data dropped, N+4 latency.
    do_redirect(32'h3000_0000);
    wait_bstart("kill_wait_bstart");
    @(posedge clk);
    #1;
    chk("kill_wait_bdone", 32'(bus.bdone), 32'd1);
    expect_entry(32'hF000_0100, 32'hF000_0100, 1'b0);
    expect_entry(32'hF000_0104, 32'hF000_0104, 1'b0);
    do_redirect(32'hF000_0100);
    inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("latency_n3_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    chk("latency_n4_valid", 32'(inst_valid), 32'd1);
    drain(100);

    // Bus error on the third fetch.
    err_addr = 32'h2000_0008;
    expect_entry(32'h2000_0000, 32'h2000_0000, 1'b0);
    expect_entry(32'h2000_0004, 32'h2000_0004, 1'b0);
    expect_entry(32'h2000_0008, 32'h0000_0000, 1'b1);
    do_redirect(32'h2000_0000);
    inst_ready = 1'b1;
    drain(100);
    check_bus_idle("berror_halt_bus_idle", 10);
    chk("berror_halt_no_inst", 32'(inst_valid), 32'd0);
    err_addr = 32'hFFFF_FFFF;

    // Unmapped address: fault after the completion timeout.
    expect_entry(UNMAPPED, 32'h0000_0000, 1'b1);
    do_redirect(UNMAPPED);
    inst_ready = 1'b1;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (inst_valid) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat >= 66 && lat <= 70) n_pass++;
    else $display("FAIL timeout_latency: got %0d cycles, required 66..70", lat);
    drain(20);
    check_bus_idle("timeout_halt_bus_idle", 10);

    // Misaligned redirect: immediate fault, no bus transaction.
    expect_entry(32'h2000_0002, 32'h0000_0000, 1'b1);
    do_redirect(32'h2000_0002);
    inst_ready = 1'b1;
    seen_bstart = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen_bstart = seen_bstart | bus.bstart;
    end
    chk("misaligned_no_bstart", 32'(seen_bstart), 32'd0);
    drain(20);

    // Reset in the middle of a transaction; the late bdone is ignored.
    do_redirect(32'h2000_0000);
    wait_bstart("rst_mid_bstart");
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_late_bdone", 32'(bus.bdone), 32'd1);
    chk("rst_mid_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_mid_breq",       32'(bus.breq),   32'd0);
    rst_n = 1'b1;
    expect_entry(32'h2000_0000, 32'h2000_0000, 1'b0);
    expect_entry(32'h2000_0004, 32'h2000_0004, 1'b0);
    @(posedge clk);
    #1 inst_ready = 1'b1;
    drain(100);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time limit, required finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
